// File: rtl/memarb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
// Holds the FSM state encoding, default bus widths and the all-bytes-enabled constant.
package memarb_pkg;

  localparam int unsigned ADDR_W_DFLT = 32;
  localparam int unsigned DATA_W_DFLT = 32;

  localparam logic [DATA_W_DFLT/8-1:0] ALL_BE = '1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssueIf = 3'd1,
    StIssueDm = 3'd2,
    StRespIf  = 3'd3,
    StRespDm  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, the pipeline (fetch + MEM stage) and the memory bus.
//   master : arbiter view (pipeline requests and bus ack/rdata in; bus fields, done, stall out)
//   slave  : environment view (pipeline and memory), directions mirrored
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = memarb_pkg::ADDR_W_DFLT,
  parameter int unsigned DATA_W = memarb_pkg::DATA_W_DFLT
);

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  // Data port
  logic                dm_req;
  logic                dm_we;
  logic [DATA_W/8-1:0] dm_be;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W-1:0]   dm_rdata;
  logic                dm_done;

  // Memory bus
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  // Hazard / status
  logic stall_if;
  logic stall_dm;
  logic bus_err;

  modport master (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output stall_if, stall_dm, bus_err
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  stall_if, stall_dm, bus_err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Bus watchdog: counts enabled cycles and pulses `expired` on the TIMEOUT_CYC-th one.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count this cycle (waiting for ack)
//   expired    : combinational pulse, high on the TIMEOUT_CYC-th enabled cycle
// TIMEOUT_CYC = 0 removes the counter and ties expired low.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clr, en};
    assign expired = 1'b0;
  end else begin : g_on
    // Only needs to reach TIMEOUT_CYC-1: expiry always forces a state change, which clears it.
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = en & (cnt_q == CntW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between instruction fetch and the MEM stage.
// Data requests have fixed priority; each transaction is IDLE -> ISSUE -> RESP -> IDLE.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_port_arbiter_if.master (fetch port, data port, memory bus, stalls, bus_err)
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYC (max ISSUE cycles without ack, 0 = no watchdog).
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DFLT,
  parameter int unsigned DATA_W      = DATA_W_DFLT,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned BeW = DATA_W / 8;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BeW-1:0]    mem_be_q, mem_be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              drop_q, drop_d;
  logic              bus_err_q, bus_err_d;

  logic in_issue;
  logic wd_en;
  logic wd_clr;
  logic wd_expired;
  logic if_done;
  logic dm_done;

  assign in_issue = (state_q == StIssueIf) || (state_q == StIssueDm);
  assign wd_en    = in_issue & ~bus.mem_ack;
  assign wd_clr   = (state_d != state_q);

  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    drop_d      = drop_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.dm_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_be_d    = bus.dm_be;
          state_d     = StIssueDm;
        end else if (bus.if_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          mem_be_d   = {BeW{1'b1}};
          state_d    = StIssueIf;
        end
      end
      StIssueIf, StIssueDm: begin
        if ((state_q == StIssueIf) && bus.if_flush) begin
          drop_d = 1'b1;
        end
        // Ack wins over a same-cycle watchdog expiry.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
          state_d   = (state_q == StIssueIf) ? StRespIf : StRespDm;
        end else if (wd_expired) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = (state_q == StIssueIf) ? StRespIf : StRespDm;
        end
      end
      StRespIf: begin
        // The fetch result is already committed or dropped; a flush here has nothing left to cancel.
        drop_d  = 1'b0;
        state_d = StIdle;
      end
      StRespDm: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
      drop_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      drop_q      <= drop_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Done pulses decode registered state only, so no input reaches them combinationally.
  assign if_done = (state_q == StRespIf) & ~drop_q;
  assign dm_done = (state_q == StRespDm);

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_done   = if_done;
  assign bus.dm_done   = dm_done;
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_done;
  assign bus.stall_dm  = bus.dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle watchdog and a wait-state memory model.
module tb_mem_port_arbiter;
  import memarb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  int          mem_wait = 0;
  bit          mem_hang = 1'b0;
  logic [31:0] mem_data = '0;
  int          ack_count = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory: acks on the (mem_wait+1)-th cycle of mem_req, garbage rdata otherwise.
  initial begin : mem_model
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req && !mem_hang && (wcnt == mem_wait)) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem_data;
        ack_count++;
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        wcnt = bus.mem_req ? wcnt + 1 : 0;
      end
    end
  end

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin failures++; $display("FAIL rst_mem_fields got=%h/%h/%h exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    checks++; if ({bus.if_done, bus.dm_done} !== 2'b00) begin failures++; $display("FAIL rst_done got=%b exp=00", {bus.if_done, bus.dm_done}); end
    checks++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", bus.if_rdata, bus.dm_rdata); end
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL rst_bus_err got=%0h exp=0", bus.bus_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_if_zero_wait();
    mem_wait = 0;
    mem_data = 32'h0000_0013;
    bus.if_addr = 32'h0000_0040;
    bus.if_req = 1'b1;
    #1;
    checks++; if (bus.stall_if !== 1'b1) begin failures++; $display("FAIL ifz_stall_n got=%0h exp=1", bus.stall_if); end
    tick();
    checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) begin failures++; $display("FAIL ifz_issue_n1 got=%0h/%h exp=1/00000040", bus.mem_req, bus.mem_addr); end
    checks++; if ({bus.stall_if, bus.if_done} !== 2'b10) begin failures++; $display("FAIL ifz_stall_n1 got=%b exp=10", {bus.stall_if, bus.if_done}); end
    tick();
    checks++; if ({bus.if_done, bus.if_rdata} !== {1'b1, 32'h13}) begin failures++; $display("FAIL ifz_done_n2 got=%0h/%h exp=1/00000013", bus.if_done, bus.if_rdata); end
    checks++; if ({bus.stall_if, bus.mem_req} !== 2'b00) begin failures++; $display("FAIL ifz_stall_n2 got=%b exp=00", {bus.stall_if, bus.mem_req}); end
    bus.if_req = 1'b0;
    tick();
    checks++; if (bus.if_done !== 1'b0) begin failures++; $display("FAIL ifz_done_n3 got=%0h exp=0", bus.if_done); end
  endtask

  task automatic test_dm_priority();
    mem_wait = 0;
    mem_data = 32'h1234_5678;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_be = ALL_BE;
    bus.dm_addr = 32'h0000_0100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.if_addr = 32'h0000_0040;
    bus.if_req = 1'b1;
    tick();
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin failures++; $display("FAIL pri_dm_fields got=%0h/%0h/%h/%h/%h exp=1/1/f/00000100/deadbeef", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    tick();
    checks++; if ({bus.dm_done, bus.dm_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL pri_dm_done got=%0h/%h exp=1/00000000", bus.dm_done, bus.dm_rdata); end
    checks++; if ({bus.if_done, bus.stall_if, bus.stall_dm} !== 3'b010) begin failures++; $display("FAIL pri_if_wait got=%b exp=010", {bus.if_done, bus.stall_if, bus.stall_dm}); end
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL pri_idle_n3 got=%0h exp=0", bus.mem_req); end
    tick();
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin failures++; $display("FAIL pri_if_issue_n4 got=%0h/%0h/%h/%h exp=1/0/f/00000040", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); end
    tick();
    checks++; if ({bus.if_done, bus.if_rdata} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL pri_if_done_n5 got=%0h/%h exp=1/12345678", bus.if_done, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_load_wait3();
    mem_wait = 3;
    mem_data = 32'hCAFE_F00D;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_be = 4'b0011;
    bus.dm_addr = 32'h0000_0200;
    bus.dm_wdata = 32'h0000_0055;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.dm_done} !== {1'b1, 1'b0, 4'h3, 32'h200, 1'b0}) begin failures++; $display("FAIL ld3_stable_c%0d got=%0h/%0h/%h/%h/%0h exp=1/0/3/00000200/0", i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.dm_done); end
    end
    tick();
    checks++; if ({bus.dm_done, bus.dm_rdata} !== {1'b1, 32'hCAFEF00D}) begin failures++; $display("FAIL ld3_done_n5 got=%0h/%h exp=1/cafef00d", bus.dm_done, bus.dm_rdata); end
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL ld3_no_err got=%0h exp=0", bus.bus_err); end
    bus.dm_req = 1'b0;
    tick();
    mem_wait = 0;
  endtask

  task automatic test_flush();
    int acks0;
    mem_wait = 1;
    mem_data = 32'hAAAA_0001;
    acks0 = ack_count;
    bus.if_addr = 32'h0000_0080;
    bus.if_req = 1'b1;
    tick();
    checks++; if ({bus.mem_req, bus.mem_be} !== {1'b1, 4'hF}) begin failures++; $display("FAIL fl_issue got=%0h/%h exp=1/f", bus.mem_req, bus.mem_be); end
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    checks++; if ({bus.mem_req, bus.if_done} !== 2'b10) begin failures++; $display("FAIL fl_issue2 got=%b exp=10", {bus.mem_req, bus.if_done}); end
    tick();
    checks++; if (bus.if_done !== 1'b0) begin failures++; $display("FAIL fl_done_suppressed got=%0h exp=0", bus.if_done); end
    checks++; if (ack_count !== acks0 + 1) begin failures++; $display("FAIL fl_bus_completed got=%0d exp=%0d", ack_count, acks0 + 1); end
    bus.if_req = 1'b0;
    tick();
    checks++; if ({bus.mem_req, bus.if_done} !== 2'b00) begin failures++; $display("FAIL fl_idle got=%b exp=00", {bus.mem_req, bus.if_done}); end
    // Flush while idle must not affect the next fetch.
    mem_wait = 0;
    mem_data = 32'h0000_0067;
    bus.if_req = 1'b1;
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL fl_refetch_issue got=%0h exp=1", bus.mem_req); end
    tick();
    checks++; if ({bus.if_done, bus.if_rdata} !== {1'b1, 32'h67}) begin failures++; $display("FAIL fl_refetch_done got=%0h/%h exp=1/00000067", bus.if_done, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    mem_hang = 1'b1;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_be = 4'hF;
    bus.dm_addr = 32'h0000_0300;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if ({bus.mem_req, bus.dm_done, bus.bus_err} !== 3'b100) begin failures++; $display("FAIL to_wait_c%0d got=%b exp=100", i, {bus.mem_req, bus.dm_done, bus.bus_err}); end
    end
    tick();
    checks++; if ({bus.dm_done, bus.dm_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL to_done got=%0h/%h exp=1/00000000", bus.dm_done, bus.dm_rdata); end
    checks++; if ({bus.bus_err, bus.mem_req} !== 2'b10) begin failures++; $display("FAIL to_err got=%b exp=10", {bus.bus_err, bus.mem_req}); end
    bus.dm_req = 1'b0;
    mem_hang = 1'b0;
    tick();
    checks++; if ({bus.bus_err, bus.dm_done} !== 2'b10) begin failures++; $display("FAIL to_sticky1 got=%b exp=10", {bus.bus_err, bus.dm_done}); end
    mem_data = 32'h0000_0099;
    bus.if_addr = 32'h0000_0044;
    bus.if_req = 1'b1;
    tick();
    tick();
    checks++; if ({bus.if_done, bus.if_rdata, bus.bus_err} !== {1'b1, 32'h99, 1'b1}) begin failures++; $display("FAIL to_sticky2 got=%0h/%h/%0h exp=1/00000099/1", bus.if_done, bus.if_rdata, bus.bus_err); end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    mem_hang = 1'b1;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_be = 4'hF;
    bus.dm_addr = 32'h0000_0400;
    bus.dm_wdata = 32'h1122_3344;
    tick();
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rmi_in_issue got=%0h exp=1", bus.mem_req); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 70'h0) begin failures++; $display("FAIL rmi_bus_zero got=%0h/%0h/%h/%h/%h exp=0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    checks++; if ({bus.if_done, bus.dm_done, bus.bus_err, bus.if_rdata, bus.dm_rdata} !== 67'h0) begin failures++; $display("FAIL rmi_status_zero got=%0h/%0h/%0h/%h/%h exp=0", bus.if_done, bus.dm_done, bus.bus_err, bus.if_rdata, bus.dm_rdata); end
    mem_hang = 1'b0;
    mem_data = 32'h7777_0001;
    bus.dm_we = 1'b0;
    bus.dm_addr = 32'h0000_0404;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h404}) begin failures++; $display("FAIL rmi_fresh_issue got=%0h/%0h/%h exp=1/0/00000404", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    checks++; if ({bus.dm_done, bus.dm_rdata, bus.bus_err} !== {1'b1, 32'h77770001, 1'b0}) begin failures++; $display("FAIL rmi_fresh_done got=%0h/%h/%0h exp=1/77770001/0", bus.dm_done, bus.dm_rdata, bus.bus_err); end
    bus.dm_req = 1'b0;
    tick();
  endtask

  initial begin : main
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_be = '0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    test_reset();
    test_if_zero_wait();
    test_dm_priority();
    test_load_wait3();
    test_flush();
    test_timeout();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
